// File: rtl/perceptron_trainable.sv
// Trainable single-layer perceptron: N_IN binary features, signed saturating weights and a bias.
// One shared adder serves inference (MAC) and training; PERCEPTRON_WLOAD_EN adds a weight load port.
module perceptron_trainable #(
  parameter int N_IN   = 16,
  parameter int W_W    = 8,
  parameter int LR     = 1,
  parameter int INIT_W = 0,
  localparam int IDX_W = $clog2(N_IN + 1),
  localparam int ACC_W = W_W + $clog2(N_IN + 1) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    train,
  input  logic [N_IN-1:0]         x,
  input  logic                    label,
`ifdef PERCEPTRON_WLOAD_EN
  input  logic                    wl_en,
  input  logic [IDX_W-1:0]        wl_addr,
  input  logic signed [W_W-1:0]   wl_data,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    classification,
  output logic signed [ACC_W-1:0] sum,
  output logic                    updated
);

  typedef enum logic [2:0] {IDLE, ACCUM, DECIDE, UPDATE, FIN} state_t;

  localparam logic [IDX_W-1:0]        LAST_FEAT = IDX_W'(N_IN - 1);
  localparam logic [IDX_W-1:0]        BIAS_IDX  = IDX_W'(N_IN);
  localparam logic signed [ACC_W-1:0] W_MAX     = ACC_W'((1 << (W_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] W_MIN     = ACC_W'(-(1 << (W_W - 1)));
  localparam logic signed [ACC_W-1:0] LR_EXT    = ACC_W'(LR);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [N_IN-1:0]         x_q, x_d;
  logic                    train_q, train_d, label_q, label_d;
  logic                    upd_ran_q, upd_ran_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d;
  logic                    class_q, class_d, done_q, done_d, updated_q, updated_d;

  // Entry N_IN holds the bias; it behaves as a weight whose feature is always 1.
  logic signed [W_W-1:0]   w_q [N_IN+1];
  logic [N_IN:0]           w_we;
  logic signed [W_W-1:0]   w_wdata;

  logic [N_IN:0]           x_ext;
  logic                    feat;
  logic signed [ACC_W-1:0] w_sel_ext, add_a, add_b, add_y;
  logic signed [W_W-1:0]   w_sat;
  logic                    decision;

  assign x_ext     = {1'b1, x_q};
  assign feat      = x_ext[idx_q];
  assign w_sel_ext = ACC_W'(w_q[idx_q]);
  assign decision  = ~acc_q[ACC_W-1];

  always_comb begin
    if (state_q == UPDATE) begin
      add_a = w_sel_ext;
      add_b = label_q ? LR_EXT : -LR_EXT;
    end else begin
      add_a = acc_q;
      add_b = feat ? w_sel_ext : '0;
    end
  end

  assign add_y = add_a + add_b;

  always_comb begin
    if (add_y > W_MAX) begin
      w_sat = W_MAX[W_W-1:0];
    end else if (add_y < W_MIN) begin
      w_sat = W_MIN[W_W-1:0];
    end else begin
      w_sat = add_y[W_W-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    x_d       = x_q;
    train_d   = train_q;
    label_d   = label_q;
    upd_ran_d = upd_ran_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    class_d   = class_q;
    done_d    = 1'b0;
    updated_d = 1'b0;
    w_we      = '0;
    w_wdata   = w_sat;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d       = x;
          train_d   = train;
          label_d   = label;
          acc_d     = ACC_W'(w_q[N_IN]);
          idx_d     = '0;
          upd_ran_d = 1'b0;
          state_d   = ACCUM;
`ifdef PERCEPTRON_WLOAD_EN
        end else if (wl_en && (wl_addr <= BIAS_IDX)) begin
          w_we[wl_addr] = 1'b1;
          w_wdata       = wl_data;
`endif
        end
      end
      ACCUM: begin
        acc_d = add_y;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_FEAT) begin
          state_d = DECIDE;
        end
      end
      DECIDE: begin
        class_d = decision;
        sum_d   = acc_q;
        idx_d   = '0;
        if (train_q && (label_q != decision)) begin
          upd_ran_d = 1'b1;
          state_d   = UPDATE;
        end else begin
          state_d = FIN;
        end
      end
      UPDATE: begin
        // Inactive features are skipped; the bias entry always sees feat=1.
        w_we[idx_q] = feat;
        idx_d       = idx_q + 1'b1;
        if (idx_q == BIAS_IDX) begin
          state_d = FIN;
        end
      end
      FIN: begin
        done_d    = 1'b1;
        updated_d = upd_ran_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      x_q       <= '0;
      train_q   <= 1'b0;
      label_q   <= 1'b0;
      upd_ran_q <= 1'b0;
      acc_q     <= '0;
      sum_q     <= '0;
      class_q   <= 1'b0;
      done_q    <= 1'b0;
      updated_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      x_q       <= x_d;
      train_q   <= train_d;
      label_q   <= label_d;
      upd_ran_q <= upd_ran_d;
      acc_q     <= acc_d;
      sum_q     <= sum_d;
      class_q   <= class_d;
      done_q    <= done_d;
      updated_q <= updated_d;
    end
  end

  for (genvar gi = 0; gi <= N_IN; gi++) begin : g_w
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        w_q[gi] <= W_W'(INIT_W);
      end else if (w_we[gi]) begin
        w_q[gi] <= w_wdata;
      end
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign classification = class_q;
  assign sum            = sum_q;
  assign updated        = updated_q;

endmodule
